// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD pixel FIFO fill controller.
// Holds the FSM encoding, default frame geometry and flush length.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        WAIT_ROOM,
        REQ,
        DATA,
        DONE
    } state_t;

    localparam int unsigned LCD_H_ACTIVE = 800;
    localparam int unsigned LCD_V_ACTIVE = 480;
    localparam int unsigned FRAME_PIXELS = LCD_H_ACTIVE * LCD_V_ACTIVE;
    localparam int unsigned FLUSH_LEN    = 4;

    function automatic logic [7:0] burst_len(
        input logic [18:0] rem,
        input logic [18:0] burst
    );
        return (rem < burst) ? rem[7:0] : burst[7:0];
    endfunction

endpackage

// File: rtl/lcd_fifo_fill_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             PixelClk,
    input  logic             nRST,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/lcd_fifo_fill_ctrl.sv
// Keeps the LCD pixel FIFO topped up from the framebuffer in bursts.
// A VSYNC falling edge flushes the FIFO and restarts at address 0.
module lcd_fifo_fill_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = LCD_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = LCD_V_ACTIVE,
    parameter int unsigned BURST      = 64,
    parameter int unsigned FIFO_DEPTH = 1024
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        LCD_VSYNC,
    input  logic        LCD_DE,
    input  logic [10:0] FIFO_Level,
    input  logic        FIFO_Empty,
    output logic        FIFO_WE,
    output logic [15:0] FIFO_WData,
    output logic        FIFO_RST,
    output logic        RD_REQ,
    output logic [18:0] RD_ADDR,
    output logic [7:0]  RD_LEN,
    input  logic        RD_ACK,
    input  logic        RD_VALID,
    input  logic [15:0] RD_DATA,
    output logic        FRAME_DONE,
    output logic [15:0] UNDERRUN_CNT
);

    localparam logic [18:0] FRAME_W  = 19'(H_ACTIVE * V_ACTIVE);
    localparam logic [18:0] BURST_W  = 19'(BURST);
    localparam logic [11:0] ROOM_LIM = 12'(FIFO_DEPTH - BURST);
    localparam logic [2:0]  FL_LAST  = 3'(FLUSH_LEN - 1);

    state_t      state_q, state_d;
    logic        vs_q;
    logic        pend_q, pend_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [18:0] addr_q, addr_d;
    logic [18:0] rem_q, rem_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic        done_q, done_d;
    logic        we_q;
    logic [15:0] wdata_q;
    logic        fs;
    logic        last_beat;
    logic [7:0]  cur_len;

    assign fs        = vs_q & ~LCD_VSYNC;
    assign cur_len   = burst_len(rem_q, BURST_W);
    assign last_beat = (beat_q == (len_q - 8'd1));

    // next-state, address bookkeeping and pending-restart tracking
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        fcnt_d  = fcnt_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        len_d   = len_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        if (fs && ((state_q == DATA) || (state_q == FLUSH))) begin
            pend_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (fs) state_d = FLUSH;
            end
            FLUSH: begin
                addr_d = '0;
                rem_d  = FRAME_W;
                fcnt_d = fcnt_q + 3'd1;
                if (fcnt_q == FL_LAST) begin
                    state_d = WAIT_ROOM;
                    fcnt_d  = '0;
                end
            end
            WAIT_ROOM: begin
                if (fs) begin
                    state_d = FLUSH;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                end else if ({1'b0, FIFO_Level} <= ROOM_LIM) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (fs) begin
                    state_d = FLUSH;
                end else if (RD_ACK) begin
                    state_d = DATA;
                    len_d   = cur_len;
                    beat_d  = '0;
                end
            end
            DATA: begin
                if (RD_VALID) begin
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        addr_d  = addr_q + {11'd0, len_q};
                        rem_d   = rem_q - {11'd0, len_q};
                        done_d  = (rem_q == {11'd0, len_q});
                        state_d = (pend_q || fs) ? FLUSH : WAIT_ROOM;
                    end
                end
            end
            DONE: begin
                if (fs) state_d = FLUSH;
            end
            default: state_d = IDLE;
        endcase
        if ((state_d == FLUSH) && (state_q != FLUSH)) begin
            pend_d = 1'b0;
            fcnt_d = '0;
        end
    end

    // control state registers
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            vs_q    <= 1'b1;
            pend_q  <= 1'b0;
            fcnt_q  <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= LCD_VSYNC;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    // registered FIFO write port, fed only by beats inside DATA
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            we_q <= (state_q == DATA) && RD_VALID;
            if ((state_q == DATA) && RD_VALID) wdata_q <= RD_DATA;
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_underrun (
        .PixelClk (PixelClk),
        .nRST     (nRST),
        .inc      (LCD_DE & FIFO_Empty & (state_q != IDLE)),
        .clr      (state_q == FLUSH),
        .count    (UNDERRUN_CNT)
    );

    assign FIFO_WE    = we_q;
    assign FIFO_WData = wdata_q;
    assign FIFO_RST   = (state_q == FLUSH);
    assign RD_REQ     = (state_q == REQ) && !fs;
    assign RD_ADDR    = (state_q == REQ) ? addr_q : '0;
    assign RD_LEN     = (state_q == REQ) ? cur_len : '0;
    assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_lcd_fifo_fill_ctrl.sv
// Bench for lcd_fifo_fill_ctrl on a reduced 100x10 frame.
// Write data is scoreboarded; threshold cases come from a table.
module tb_lcd_fifo_fill_ctrl;

    localparam int BURST = 64;
    localparam int FRAME = 1000;

    logic        PixelClk = 1'b0;
    logic        nRST;
    logic        LCD_VSYNC;
    logic        LCD_DE;
    logic [10:0] FIFO_Level;
    logic        FIFO_Empty;
    logic        FIFO_WE;
    logic [15:0] FIFO_WData;
    logic        FIFO_RST;
    logic        RD_REQ;
    logic [18:0] RD_ADDR;
    logic [7:0]  RD_LEN;
    logic        RD_ACK;
    logic        RD_VALID;
    logic [15:0] RD_DATA;
    logic        FRAME_DONE;
    logic [15:0] UNDERRUN_CNT;

    lcd_fifo_fill_ctrl #(
        .H_ACTIVE   (100),
        .V_ACTIVE   (10),
        .BURST      (BURST),
        .FIFO_DEPTH (1024)
    ) dut (
        .PixelClk     (PixelClk),
        .nRST         (nRST),
        .LCD_VSYNC    (LCD_VSYNC),
        .LCD_DE       (LCD_DE),
        .FIFO_Level   (FIFO_Level),
        .FIFO_Empty   (FIFO_Empty),
        .FIFO_WE      (FIFO_WE),
        .FIFO_WData   (FIFO_WData),
        .FIFO_RST     (FIFO_RST),
        .RD_REQ       (RD_REQ),
        .RD_ADDR      (RD_ADDR),
        .RD_LEN       (RD_LEN),
        .RD_ACK       (RD_ACK),
        .RD_VALID     (RD_VALID),
        .RD_DATA      (RD_DATA),
        .FRAME_DONE   (FRAME_DONE),
        .UNDERRUN_CNT (UNDERRUN_CNT)
    );

    always #5 PixelClk = ~PixelClk;

    typedef struct {
        logic [15:0] d;
        int          c;
    } beat_t;

    typedef struct {
        logic [10:0] level;
        bit          req;
    } vec_t;

    beat_t sbq[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    int    fd_cnt = 0;
    int    exp_addr;
    int    exp_rem;

    always @(posedge PixelClk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge PixelClk);
        #1;
    endtask

    // write-port scoreboard and frame-done watcher
    always @(negedge PixelClk) begin
        beat_t b;
        if (nRST === 1'b1) begin
            if (FRAME_DONE) begin
                fd_cnt++;
                chk("fd_with_we", {31'd0, FIFO_WE}, 32'd1);
            end
            if (FIFO_WE) begin
                if (sbq.size() == 0) begin
                    chk("we_unexpected", {31'd0, FIFO_WE}, 32'd0);
                end else begin
                    b = sbq.pop_front();
                    chk("wdata", {16'd0, FIFO_WData}, {16'd0, b.d});
                    chk("we_latency", cyc, b.c + 1);
                end
            end
        end
    end

    task automatic vs_pulse();
        LCD_VSYNC = 1'b0;
        tick();
        LCD_VSYNC = 1'b1;
    endtask

    task automatic chk_flush();
        int n = 0;
        for (int i = 0; i < 12; i++) begin
            if (FIFO_RST) n++;
            tick();
        end
        chk("flush_len", n, 4);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (RD_REQ) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_burst(input int dly, input bit park, input int vs_at);
        bit         ok;
        logic [7:0] el;
        beat_t      b;
        wait_req(ok);
        if (!ok) return;
        el = (exp_rem < BURST) ? 8'(exp_rem) : 8'(BURST);
        chk("rd_addr", {13'd0, RD_ADDR}, exp_addr);
        chk("rd_len", {24'd0, RD_LEN}, {24'd0, el});
        for (int d = 0; d < dly; d++) begin
            RD_VALID = 1'b1;
            RD_DATA  = 16'hDEAD;
            tick();
            RD_VALID = 1'b0;
            chk("req_hold", {31'd0, RD_REQ}, 32'd1);
            chk("addr_hold", {13'd0, RD_ADDR}, exp_addr);
            chk("len_hold", {24'd0, RD_LEN}, {24'd0, el});
        end
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
        chk("req_drop", {31'd0, RD_REQ}, 32'd0);
        for (int i = 0; i < el; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            if (i == vs_at) LCD_VSYNC = 1'b0;
            if (park && (i == el - 1)) FIFO_Level = 11'd1023;
            RD_VALID = 1'b1;
            RD_DATA  = 16'($urandom);
            b.d = RD_DATA;
            b.c = cyc;
            sbq.push_back(b);
            tick();
            RD_VALID  = 1'b0;
            LCD_VSYNC = 1'b1;
        end
        exp_addr += el;
        exp_rem  -= el;
    endtask

    initial begin
        vec_t tbl[9];
        bit   ok;
        int   nb;
        int   reqs;

        tbl[0] = '{11'd2047, 1'b0};
        tbl[1] = '{11'd1024, 1'b0};
        tbl[2] = '{11'd961,  1'b0};
        tbl[3] = '{11'd960,  1'b1};
        tbl[4] = '{11'd1000, 1'b0};
        tbl[5] = '{11'd500,  1'b1};
        tbl[6] = '{11'd0,    1'b1};
        tbl[7] = '{11'd961,  1'b0};
        tbl[8] = '{11'd959,  1'b1};

        nRST       = 1'b0;
        LCD_VSYNC  = 1'b1;
        LCD_DE     = 1'b0;
        FIFO_Level = '0;
        FIFO_Empty = 1'b0;
        RD_ACK     = 1'b0;
        RD_VALID   = 1'b0;
        RD_DATA    = '0;
        exp_addr   = 0;
        exp_rem    = FRAME;

        repeat (3) tick();
        chk("rst_we", {31'd0, FIFO_WE}, 32'd0);
        chk("rst_wdata", {16'd0, FIFO_WData}, 32'd0);
        chk("rst_fifo_rst", {31'd0, FIFO_RST}, 32'd0);
        chk("rst_req", {31'd0, RD_REQ}, 32'd0);
        chk("rst_addr", {13'd0, RD_ADDR}, 32'd0);
        chk("rst_len", {24'd0, RD_LEN}, 32'd0);
        chk("rst_fd", {31'd0, FRAME_DONE}, 32'd0);
        chk("rst_under", {16'd0, UNDERRUN_CNT}, 32'd0);
        nRST = 1'b1;
        repeat (4) tick();
        chk("idle_no_req", {31'd0, RD_REQ}, 32'd0);

        vs_pulse();
        chk_flush();
        do_burst(5, 1'b1, -1);

        for (int v = 0; v < 9; v++) begin
            FIFO_Level = tbl[v].level;
            tick();
            chk("room_req", {31'd0, RD_REQ}, {31'd0, tbl[v].req});
            if (tbl[v].req) begin
                do_burst(int'($urandom_range(0, 2)), 1'b1, -1);
            end else begin
                tick();
                tick();
                chk("room_hold", {31'd0, RD_REQ}, 32'd0);
            end
        end

        FIFO_Level = '0;
        do_burst(0, 1'b0, 10);
        chk("flush_after_burst", {31'd0, FIFO_RST}, 32'd1);
        chk_flush();
        exp_addr = 0;
        exp_rem  = FRAME;

        nb = 0;
        while ((exp_rem > 0) && (nb < 40)) begin
            do_burst(int'($urandom_range(0, 2)), 1'b0, -1);
            nb++;
        end
        chk("bursts", nb, 16);
        tick();
        tick();
        chk("frame_done_cnt", fd_cnt, 1);
        reqs = 0;
        for (int i = 0; i < 30; i++) begin
            if (RD_REQ) reqs++;
            tick();
        end
        chk("done_no_req", reqs, 0);

        LCD_DE     = 1'b1;
        FIFO_Empty = 1'b1;
        repeat (10) tick();
        LCD_DE = 1'b0;
        chk("under_10", {16'd0, UNDERRUN_CNT}, 32'd10);
        LCD_DE = 1'b1;
        repeat (65600) tick();
        chk("under_sat", {16'd0, UNDERRUN_CNT}, 32'h0000FFFF);
        LCD_DE = 1'b0;
        vs_pulse();
        tick();
        tick();
        chk("under_clr", {16'd0, UNDERRUN_CNT}, 32'd0);
        FIFO_Empty = 1'b0;

        wait_req(ok);
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat_t b;
            RD_VALID = 1'b1;
            RD_DATA  = 16'(16'h1000 + i);
            b.d = RD_DATA;
            b.c = cyc;
            sbq.push_back(b);
            tick();
        end
        RD_VALID = 1'b0;
        tick();
        tick();
        chk("sb_drained", sbq.size(), 0);
        nRST = 1'b0;
        tick();
        chk("mid_rst_we", {31'd0, FIFO_WE}, 32'd0);
        chk("mid_rst_wdata", {16'd0, FIFO_WData}, 32'd0);
        chk("mid_rst_req", {31'd0, RD_REQ}, 32'd0);
        nRST = 1'b1;
        RD_VALID = 1'b1;
        repeat (5) tick();
        RD_VALID = 1'b0;
        chk("post_rst_idle", {31'd0, RD_REQ}, 32'd0);
        chk("post_rst_nflush", {31'd0, FIFO_RST}, 32'd0);
        vs_pulse();
        chk_flush();
        exp_addr = 0;
        exp_rem  = FRAME;
        do_burst(1, 1'b0, -1);
        repeat (4) tick();
        chk("sb_final", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_fifo_fill_ctrl.md
LCD_FIFO_FILL_CTRL -- requirements
Module: lcd_fifo_fill_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 800, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter BURST, default 64, maximum words per framebuffer read burst.
REQ-004 Parameter FIFO_DEPTH, default 1024, depth of the pixel FIFO in 16-bit words.
REQ-005 PixelClk  in  1  clock; every flop in the block is clocked on its rising edge.
REQ-006 nRST  in  1  reset, asynchronous, active-low.
REQ-007 LCD_VSYNC  in  1  active-low vertical sync from the timing generator.
REQ-008 LCD_DE  in  1  display data enable from the timing generator.
REQ-009 FIFO_Level  in  11  current word count of the pixel FIFO.
REQ-010 FIFO_Empty  in  1  pixel FIFO empty flag.
REQ-011 FIFO_WE  out  1  pixel FIFO write strobe.
REQ-012 FIFO_WData  out  16  RGB565 word to write into the pixel FIFO.
REQ-013 FIFO_RST  out  1  synchronous flush of the pixel FIFO.
REQ-014 RD_REQ  out  1  framebuffer burst read request.
REQ-015 RD_ADDR  out  19  framebuffer word address of the burst.
REQ-016 RD_LEN  out  8  burst length in words.
REQ-017 RD_ACK  in  1  framebuffer accepts the request.
REQ-018 RD_VALID  in  1  read data beat valid.
REQ-019 RD_DATA  in  16  read data beat.
REQ-020 FRAME_DONE  out  1  one-cycle pulse when the last pixel of the frame is written.
REQ-021 UNDERRUN_CNT  out  16  saturating count of underrun cycles in the current frame.

Function
REQ-022 The block SHALL detect the frame start as a 1->0 transition of LCD_VSYNC, using one registered sample.
REQ-023 The state machine SHALL have the states IDLE, FLUSH, WAIT_ROOM, REQ, DATA and DONE.
REQ-024 A frame start in IDLE, WAIT_ROOM, REQ or DONE SHALL move the state to FLUSH on the next edge.
REQ-025 A frame start in REQ SHALL drop RD_REQ before any acknowledge is honoured.
REQ-026 A frame start in DATA or FLUSH SHALL set a pending flag and SHALL NOT abort the current state.
REQ-027 On leaving DATA with the pending flag set, the next state SHALL be FLUSH, and the flag SHALL clear on entering FLUSH.
REQ-028 In FLUSH, FIFO_RST SHALL be high for exactly 4 cycles.
REQ-029 FLUSH SHALL clear the address to 0, load remaining with H_ACTIVE*V_ACTIVE (384000), and clear UNDERRUN_CNT.
REQ-030 After the 4 flush cycles, FLUSH SHALL go to WAIT_ROOM.
REQ-031 In WAIT_ROOM, with remaining==0, the block SHALL go to DONE.
REQ-032 In WAIT_ROOM, otherwise, the block SHALL go to REQ when FIFO_Level <= FIFO_DEPTH-BURST, and SHALL stay in WAIT_ROOM when it is not.
REQ-033 In REQ, RD_REQ SHALL be high with RD_ADDR=address and RD_LEN=min(BURST, remaining).
REQ-034 RD_REQ, RD_ADDR and RD_LEN SHALL be held stable until RD_ACK, and the state SHALL move to DATA on the RD_ACK cycle.
REQ-035 Each RD_VALID beat in DATA SHALL produce FIFO_WE=1 with FIFO_WData=RD_DATA one cycle later (registered).
REQ-036 RD_VALID outside DATA SHALL be ignored.
REQ-037 After RD_LEN beats, address SHALL increase by RD_LEN, remaining SHALL decrease by RD_LEN, and the state SHALL go to WAIT_ROOM (or FLUSH if pending).
REQ-038 FRAME_DONE SHALL pulse in the cycle remaining reaches 0.
REQ-039 DONE SHALL hold until the next frame start.
REQ-040 UNDERRUN_CNT SHALL increment on each cycle with LCD_DE=1 and FIFO_Empty=1 while not in IDLE.
REQ-041 UNDERRUN_CNT SHALL saturate at 16'hFFFF.
REQ-042 Address arithmetic SHALL be 19-bit unsigned, and the last burst of a frame SHALL be short (384000 mod 64 = 0 at defaults; any non-multiple is truncated by min()).

Reset
REQ-043 While nRST=0: state=IDLE; FIFO_WE=0, FIFO_WData=0, FIFO_RST=0, RD_REQ=0, RD_ADDR=0, RD_LEN=0, FRAME_DONE=0, UNDERRUN_CNT=0; pending flag cleared; VSYNC sample=1.
REQ-044 Reset asserted mid-burst SHALL abandon the burst, and the first frame start after release SHALL begin a full FLUSH.

Structure
REQ-045 The state encoding, the frame pixel count constant, and the flush length 4 SHALL live in a shared package lcd_pkg.
REQ-046 The saturating underrun counter SHALL be a sub-module sat_counter (WIDTH=16, inc, clr).

Verification
REQ-047 Scenario: reset, then a VSYNC falling edge, FIFO_Level=0 -> FIFO_RST high for 4 cycles, then RD_REQ with RD_ADDR=0 and RD_LEN=64.
REQ-048 Scenario: RD_ACK delayed 5 cycles -> RD_REQ, RD_ADDR and RD_LEN stable for all 5 cycles; 64 RD_VALID beats give 64 FIFO_WE, each one cycle after its beat; next RD_ADDR=64.
REQ-049 Scenario: FIFO_Level=961 -> no RD_REQ; dropping to 960 -> RD_REQ on the following cycle.
REQ-050 Scenario: VSYNC edge during beat 10 of a burst -> all 64 beats written, then FIFO_RST, then RD_ADDR=0.
REQ-051 Scenario: full frame with FIFO_Level held 0 -> 6000 bursts, FRAME_DONE pulses once with the last beat's write, then DONE with no further RD_REQ.
REQ-052 Scenario: LCD_DE=1 and FIFO_Empty=1 for 70000 cycles -> UNDERRUN_CNT=16'hFFFF; the next frame start -> 0.
